// File: rtl/rd_stream_sched.sv
// rd_stream_sched
// Command scheduler for the read_stream engine. The engine is shared across
// NUM_STREAMS frame buffers in DDR4. The scheduler walks one whole frame of a
// stream in bursts that never cross a 4 KB page. It then moves round-robin to
// the next enabled stream.
//
// Ports:
//   clk          : clock
//   reset        : synchronous, active-high reset
//   start        : pulse, leave IDLE and begin scheduling
//   stop         : pulse, halt at the next frame boundary
//   stream_en    : per-stream enable mask, sampled when choosing a stream
//   cmd_accept   : AR handshake, one per issued command
//   en           : command valid to read_stream
//   addr         : byte address of the current command
//   burst_length : beat count of the current command (not LEN-1)
//   stream_num   : stream currently being read
//   frame_done   : 1-cycle pulse on the final accept of a frame
//   frame_stream : stream of the last completed frame (held)
//   busy         : high whenever not idle
module rd_stream_sched #(
  parameter int NUM_STREAMS        = 12,
  parameter int FRAME_BYTES        = 230400,
  parameter int STREAM_ADDR_OFFSET = $clog2(FRAME_BYTES),
  parameter int STREAM_ADDR_SHIFT  = 2,
  parameter int MAX_BURST          = 20,
  parameter int BEAT_BYTES         = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [NUM_STREAMS-1:0] stream_en,
  input  logic                   cmd_accept,
  output logic                   en,
  output logic [31:0]            addr,
  output logic [7:0]             burst_length,
  output logic [7:0]             stream_num,
  output logic                   frame_done,
  output logic [7:0]             frame_stream,
  output logic                   busy
);

  localparam logic [31:0] LP_FRAME      = 32'(FRAME_BYTES);
  localparam logic [31:0] LP_BEAT       = 32'(BEAT_BYTES);
  localparam logic [31:0] LP_MAX_BURST  = 32'(MAX_BURST);
  localparam int          LP_BASE_SHIFT = STREAM_ADDR_OFFSET + STREAM_ADDR_SHIFT;
  localparam logic [7:0]  LP_LAST       = 8'(NUM_STREAMS - 1);
  localparam logic [8:0]  LP_N9         = 9'(NUM_STREAMS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_CALC,
    S_ISSUE
  } state_t;

  state_t      r_state;
  logic [31:0] r_offset;
  logic [7:0]  r_rr_ptr;
  logic        r_stop_pend;
  logic        r_en;
  logic [31:0] r_addr;
  logic [7:0]  r_burst_length;
  logic [7:0]  r_stream_num;
  logic        r_frame_done;
  logic [7:0]  r_frame_stream;

  // ---------------------------------------------------------------------
  // Round-robin search. The mask is rotated so that bit 0 is the stream
  // after rr_ptr. A priority chain then picks the lowest set rotated bit.
  // Doubling the mask lets a plain right shift act as a rotate.
  // ---------------------------------------------------------------------
  logic [NUM_STREAMS-1:0] w_rot;
  logic [7:0]             w_chain [0:NUM_STREAMS];
  logic                   w_hit;
  logic [7:0]             w_hit_idx;

  assign w_rot = NUM_STREAMS'({stream_en, stream_en} >> ({1'b0, r_rr_ptr} + 9'd1));
  assign w_chain[NUM_STREAMS] = 8'd0;

  generate
    for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_search
      logic [8:0] w_sum;
      logic [7:0] w_cand;
      // Absolute stream index for rotated position gi (wraps N-1 -> 0).
      assign w_sum  = {1'b0, r_rr_ptr} + 9'(gi + 1);
      assign w_cand = 8'((w_sum >= LP_N9) ? (w_sum - LP_N9) : w_sum);
      assign w_chain[gi] = w_rot[gi] ? w_cand : w_chain[gi+1];
    end
  endgenerate

  assign w_hit     = |stream_en;
  assign w_hit_idx = w_chain[0];

  // ---------------------------------------------------------------------
  // Burst sizing. The burst is limited by MAX_BURST, by the beats left in
  // the frame, and by the beats left in the current 4 KB page.
  // ---------------------------------------------------------------------
  logic [31:0] w_rem_beats;
  logic [31:0] w_page_beats;
  logic [31:0] w_lim;
  logic [31:0] w_bl_full;
  logic [31:0] w_base;
  logic [31:0] w_cmd_addr;
  logic [31:0] w_next_off;

  assign w_rem_beats  = (LP_FRAME - r_offset) / LP_BEAT;
  assign w_page_beats = (32'd4096 - {20'd0, r_offset[11:0]}) / LP_BEAT;
  assign w_lim        = (w_rem_beats < w_page_beats) ? w_rem_beats : w_page_beats;
  assign w_bl_full    = (w_lim < LP_MAX_BURST) ? w_lim : LP_MAX_BURST;
  assign w_base       = 32'(r_stream_num) << LP_BASE_SHIFT;
  assign w_cmd_addr   = w_base + r_offset;
  assign w_next_off   = r_offset + 32'(r_burst_length) * LP_BEAT;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_offset       <= 32'd0;
      r_rr_ptr       <= LP_LAST;
      r_stop_pend    <= 1'b0;
      r_en           <= 1'b0;
      r_addr         <= 32'd0;
      r_burst_length <= 8'd0;
      r_stream_num   <= 8'd0;
      r_frame_done   <= 1'b0;
      r_frame_stream <= 8'd0;
    end else begin
      r_frame_done <= 1'b0;
      // A stop is remembered until the next frame boundary. The clear on
      // entry to IDLE below takes priority because it is assigned later.
      if (stop && (r_state != S_IDLE)) begin
        r_stop_pend <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_en <= 1'b0;
          if (start) begin
            r_state <= S_SELECT;
          end
        end
        S_SELECT: begin
          r_en <= 1'b0;
          if (r_stop_pend) begin
            r_state     <= S_IDLE;
            r_stop_pend <= 1'b0;
          end else if (w_hit) begin
            r_stream_num <= w_hit_idx;
            r_rr_ptr     <= w_hit_idx;
            r_offset     <= 32'd0;
            r_state      <= S_CALC;
          end
        end
        S_CALC: begin
          r_burst_length <= 8'(w_bl_full);
          r_addr         <= w_cmd_addr;
          r_en           <= 1'b1;
          r_state        <= S_ISSUE;
        end
        S_ISSUE: begin
          // addr, burst_length and stream_num are held until the handshake.
          if (cmd_accept) begin
            r_en     <= 1'b0;
            r_offset <= w_next_off;
            if (w_next_off == LP_FRAME) begin
              r_frame_done   <= 1'b1;
              r_frame_stream <= r_stream_num;
              r_state        <= S_SELECT;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_en    <= 1'b0;
        end
      endcase
    end
  end

  assign en           = r_en;
  assign addr         = r_addr;
  assign burst_length = r_burst_length;
  assign stream_num   = r_stream_num;
  assign frame_done   = r_frame_done;
  assign frame_stream = r_frame_stream;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: doc/rd_stream_sched.md
Name: rd_stream_sched

Overview:
- Command scheduler for the read_stream engine; time-shares it across NUM_STREAMS frame buffers in DDR4.
- Each stream owns one frame region at base = stream_num << (STREAM_ADDR_SHIFT + STREAM_ADDR_OFFSET).
- Walks one whole frame of a stream in bursts that never cross a 4 KB boundary, then moves round-robin to the next enabled stream.
- Drives read_stream en/addr/burst_length and advances on each accepted AR handshake.

Parameters:
- NUM_STREAMS, 12: number of frame buffers (max 256).
- FRAME_BYTES, 230400: bytes per frame; must be a multiple of BEAT_BYTES.
- STREAM_ADDR_OFFSET, $clog2(FRAME_BYTES): derived; log2 of frame region size.
- STREAM_ADDR_SHIFT, 2: extra base shift; stream stride = 2^(OFFSET+SHIFT) bytes (0x100000 at defaults).
- MAX_BURST, 20: max beats per command (1..255).
- BEAT_BYTES, 64: bytes per AXI beat (512-bit bus).

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: pulse; leave IDLE and begin scheduling.
- stop, in, 1: pulse; halt at the next frame boundary.
- stream_en, in, NUM_STREAMS: per-stream enable mask, sampled in SELECT.
- cmd_accept, in, 1: AR handshake (ARVALID && ARREADY); one per issued command.
- en, out, 1: command valid to read_stream.
- addr, out, 32: byte address of the current command.
- burst_length, out, 8: beat count (not AXI LEN-1).
- stream_num, out, 8: stream currently being read.
- frame_done, out, 1: 1-cycle pulse on the final accept of a frame.
- frame_stream, out, 8: stream of the completed frame; valid with frame_done, held afterwards.
- busy, out, 1: high in any state except IDLE.

Behaviour:
- Reset values: all outputs 0. Internal state:
  - state = IDLE
  - offset = 0
  - rr_ptr = NUM_STREAMS-1, so the first stream served is the lowest enabled index.
  - stop_pend = 0
- stop_pend is set by stop in any non-IDLE state. It is cleared on entering IDLE.
- IDLE:
  - en = 0.
  - start -> SELECT.
  - stop in IDLE is ignored.
- SELECT:
  - If stop_pend -> IDLE.
  - Else search stream_en circularly starting at rr_ptr+1 (wraps NUM_STREAMS-1 -> 0).
  - Hit: stream_num = rr_ptr = hit index, offset = 0, -> CALC.
  - No hit (mask all 0): stay in SELECT, en = 0, re-evaluate every cycle.
- CALC (1 cycle, en = 0). burst_length = min(MAX_BURST, rem_frame, to_4k):
  - rem_frame = (FRAME_BYTES - offset) / BEAT_BYTES
  - to_4k = (4096 - offset[11:0]) / BEAT_BYTES
  - addr = base(stream_num) + offset, computed 32-bit with wrap and no saturation.
  - -> ISSUE.
- ISSUE:
  - en = 1. addr, burst_length and stream_num are held stable until cmd_accept.
  - On cmd_accept: offset += burst_length*BEAT_BYTES.
  - If the new offset == FRAME_BYTES: pulse frame_done, set frame_stream = stream_num, -> SELECT.
  - Otherwise -> CALC.
  - The en deassertion registers in the cycle after accept, so no double issue.
- Latency:
  - start -> first en = 3 cycles (SELECT, CALC, ISSUE).
  - accept -> next en = 2 cycles within a frame; 3 cycles across frames.
- stream_en changes take effect only at the next SELECT. Disabling the active stream mid-frame does not abort its frame.
- Simultaneous events:
  - stop with the final accept: frame_done still pulses, then SELECT -> IDLE.
  - start while busy: ignored.
- Reset mid-frame: immediate return to IDLE with the reset values above. An outstanding command is abandoned; in-flight data is not tracked here.
- Default-parameter burst pattern per 4 KB page is 20,20,20,4 beats. The final page at offset 0x38000 is one 16-beat burst. That gives 225 commands per frame.

Test Plan:
- stream_en=12'h001, start, cmd_accept 1 cycle after each en -> 225 commands at addr 0x0, 0x500, 0xA00, 0xF00 (bl 20,20,20,4), …, last addr 0x38000 bl 16; frame_done with frame_stream=0; then stream 0 restarts at addr 0x0.
- stream_en=12'h005 -> streams 0, 2, 0, 2 in order; stream 2 first addr 0x200000; frame_done pulses carry frame_stream 0, 2, 0.
- stream_en=12'h800 (only stream 11) -> base 0xB00000; after its frame the search wraps and selects stream 11 again.
- Random 0–20 cycle cmd_accept delay -> addr, burst_length and en remain stable while waiting; no 4 KB crossing; sum of bl*64 per frame = 230400.
- stop pulse at command 100 -> remaining 125 commands issued, frame_done, IDLE, busy=0; stream_en=0 after start -> busy=1, en never asserts.
- reset asserted during ISSUE -> next cycle all outputs 0 and state IDLE; a new start serves stream 0 from offset 0.
